multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Multicycle MIPS-subset control FSM with memory-wait timeout
//
// Sequences FETCH/DECODE/EXEC/MEMRD/MEMWR/WB for a small MIPS subset and
// raises datapath strobes per state. Memory requests that see no mem_ack
// within TIMEOUT cycles, and unsupported opcodes, park the controller in
// TRAP until reset.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   allow instruction execution (sampled in IDLE and at retire)
//   opcode, rd, rt        fields of the instruction held in the external IR
//   zero_flag             ALU equality result for BEQ
//   mem_ack               single-cycle memory completion strobe
//   mem_req/we/sel        memory request, write, address select (0=PC, 1=ALU)
//   ir_we, pc_we, reg_we  IR / PC / register-file write enables
//   alu_src_imm           ALU B operand = sign-extended immediate
//   pc_src                00=PC+4, 01=branch target, 10=jump target
//   dst_sel               00=rd, 01=rt, 10=r31
//   busy, err             instruction in flight; fatal-fault flag
//   retired               count of completed instructions (wraps)

module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic        zero_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic [1:0]  pc_src,
  output logic [1:0]  dst_sel,
  output logic        busy,
  output logic        err,
  output logic [15:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Last wait count at which an ack is still accepted; no ack here means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, TRAP
  } state_t;

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [15:0] retire_cnt;
  logic        retire;
  logic        mem_state;
  logic        wait_expired;
  logic        op_supported;
  logic        op_imm;
  state_t      retire_target;

  assign retired      = retire_cnt;
  assign mem_state    = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign wait_expired = !mem_ack && (wait_cnt == WAIT_LAST);
  assign op_imm       = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
  assign retire_target = run ? FETCH : IDLE;

  always_comb begin
    op_supported = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    pc_src      = 2'b00;
    dst_sel     = 2'b00;
    busy        = 1'b0;
    err         = 1'b0;

    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end

      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end else if (wait_expired) begin
          state_next = TRAP;
        end
      end

      DECODE: begin
        busy       = 1'b1;
        state_next = op_supported ? EXEC : TRAP;
      end

      EXEC: begin
        busy        = 1'b1;
        alu_src_imm = op_imm;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_JAL: state_next = WB;
          OP_LW:  state_next = MEMRD;
          OP_SW:  state_next = MEMWR;
          OP_BEQ: begin
            pc_src     = 2'b01;
            pc_we      = zero_flag;
            retire     = 1'b1;
            state_next = retire_target;
          end
          OP_J: begin
            pc_src     = 2'b10;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = retire_target;
          end
          // Opcode changed under us after DECODE: treat as a fault.
          default: state_next = TRAP;
        endcase
      end

      MEMRD, MEMWR: begin
        busy        = 1'b1;
        mem_req     = 1'b1;
        mem_sel     = 1'b1;
        mem_we      = (state == MEMWR);
        alu_src_imm = op_imm;
        if (mem_ack) begin
          if (state == MEMRD) begin
            state_next = WB;
          end else begin
            retire     = 1'b1;
            state_next = retire_target;
          end
        end else if (wait_expired) begin
          state_next = TRAP;
        end
      end

      WB: begin
        busy       = 1'b1;
        retire     = 1'b1;
        state_next = retire_target;
        case (opcode)
          OP_ADDI, OP_LW: begin
            dst_sel = 2'b01;
            reg_we  = (rt != 5'd0);
          end
          OP_JAL: begin
            dst_sel = 2'b10;
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            pc_src  = 2'b10;
          end
          default: begin
            dst_sel = 2'b00;
            reg_we  = (rd != 5'd0);
          end
        endcase
      end

      TRAP: begin
        err = 1'b1;
      end

      default: state_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      retire_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (retire) retire_cnt <= retire_cnt + 16'd1;
      // Any state change restarts the wait window, so every request state is entered at 0.
      if (state_next != state) begin
        wait_cnt <= 8'd0;
      end else if (mem_state && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - Scoreboard bench for multicycle_ctrl (TIMEOUT=4)

module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  // Control vector: {mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, alu_src_imm, pc_src, dst_sel, busy, err}
  localparam logic [12:0] MREQ   = 13'h1000;
  localparam logic [12:0] MWE    = 13'h0800;
  localparam logic [12:0] MSEL   = 13'h0400;
  localparam logic [12:0] IRWE   = 13'h0200;
  localparam logic [12:0] PCWE   = 13'h0100;
  localparam logic [12:0] REGWE  = 13'h0080;
  localparam logic [12:0] AIMM   = 13'h0040;
  localparam logic [12:0] PC_J   = 13'h0020;
  localparam logic [12:0] PC_BR  = 13'h0010;
  localparam logic [12:0] DST_31 = 13'h0008;
  localparam logic [12:0] DST_RT = 13'h0004;
  localparam logic [12:0] BUSY   = 13'h0002;
  localparam logic [12:0] ERR    = 13'h0001;
  localparam logic [12:0] NONE   = 13'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run, zero_flag, mem_ack;
  logic [5:0]  opcode;
  logic [4:0]  rd, rt;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, alu_src_imm, busy, err;
  logic [1:0]  pc_src, dst_sel;
  logic [15:0] retired;

  typedef struct {
    string       tag;
    logic [12:0] ctl;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .rd(rd), .rt(rt),
    .zero_flag(zero_flag), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .alu_src_imm(alu_src_imm), .pc_src(pc_src), .dst_sel(dst_sel), .busy(busy),
    .err(err), .retired(retired)
  );

  task automatic check_now(input string tag, input logic [12:0] ctl, input logic [15:0] ret);
    exp_t e;
    logic [12:0] obs;
    sb.push_back('{tag: tag, ctl: ctl, ret: ret});
    e = sb.pop_front();
    obs = {mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, alu_src_imm, pc_src, dst_sel, busy, err};
    vectors++;
    assert (obs === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl: observed %013b expected %013b", e.tag, obs, e.ctl);
    end
    vectors++;
    assert (retired === e.ret) else begin
      miscompares++;
      $error("FAIL %s retired: observed %04h expected %04h", e.tag, retired, e.ret);
    end
  endtask

  // One clock cycle: inputs are already driven; sample mid-cycle, then advance past the edge.
  task automatic step(input string tag, input logic [12:0] ctl, input logic [15:0] ret);
    @(negedge clk);
    check_now(tag, ctl, ret);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] ret);
    mem_ack = 1'b1;
    step("fetch_ack", MREQ | IRWE | PCWE | BUSY, ret);
    mem_ack = 1'b0;
    step("decode", BUSY, ret);
  endtask

  initial begin
    run = 1'b0; zero_flag = 1'b0; mem_ack = 1'b0; opcode = OP_R; rd = 5'd0; rt = 5'd0;
    #1 rst_n = 1'b0;
    #1 check_now("reset", NONE, 16'h0000);
    @(posedge clk); #1; rst_n = 1'b1;
    step("idle_norun", NONE, 16'h0000);
    step("idle_norun2", NONE, 16'h0000);

    // R-type rd=5, zero-wait fetch
    run = 1'b1; opcode = OP_R; rd = 5'd5; rt = 5'd0;
    step("r_idle", NONE, 16'h0000);
    fetch_decode(16'h0000);
    step("r_exec", BUSY, 16'h0000);
    step("r_wb", BUSY | REGWE, 16'h0000);

    // LW rt=0, ack on 4th request cycle (also the timeout-boundary ack)
    opcode = OP_LW; rt = 5'd0;
    fetch_decode(16'h0001);
    step("lw_exec", BUSY | AIMM, 16'h0001);
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", MREQ | MSEL | AIMM | BUSY, 16'h0001);
    mem_ack = 1'b1;
    step("lw_memrd_ack", MREQ | MSEL | AIMM | BUSY, 16'h0001);
    mem_ack = 1'b0;
    step("lw_wb", BUSY | DST_RT, 16'h0001);

    // SW with run dropped mid-instruction
    opcode = OP_SW;
    mem_ack = 1'b1;
    step("sw_fetch", MREQ | IRWE | PCWE | BUSY, 16'h0002);
    mem_ack = 1'b0; run = 1'b0;
    step("sw_decode_norun", BUSY, 16'h0002);
    step("sw_exec_norun", BUSY | AIMM, 16'h0002);
    run = 1'b1; mem_ack = 1'b1;
    step("sw_memwr", MREQ | MWE | MSEL | AIMM | BUSY, 16'h0002);
    mem_ack = 1'b0;

    // JAL writes r31 even with rd=rt=0
    opcode = OP_JAL; rd = 5'd0; rt = 5'd0;
    fetch_decode(16'h0003);
    step("jal_exec", BUSY, 16'h0003);
    step("jal_wb", BUSY | REGWE | PCWE | PC_J | DST_31, 16'h0003);

    opcode = OP_BEQ; zero_flag = 1'b0;
    fetch_decode(16'h0004);
    step("beq_nt_exec", BUSY | PC_BR, 16'h0004);
    zero_flag = 1'b1;
    fetch_decode(16'h0005);
    step("beq_t_exec", BUSY | PCWE | PC_BR, 16'h0005);
    zero_flag = 1'b0;

    opcode = OP_J;
    fetch_decode(16'h0006);
    step("j_exec", BUSY | PCWE | PC_J, 16'h0006);

    opcode = OP_ADDI; rt = 5'd7;
    fetch_decode(16'h0007);
    step("addi_exec", BUSY | AIMM, 16'h0007);
    step("addi_wb", BUSY | REGWE | DST_RT, 16'h0007);

    // R-type with rd=0 suppresses the write even though rt is nonzero
    opcode = OP_R; rd = 5'd0;
    fetch_decode(16'h0008);
    step("r0_exec", BUSY, 16'h0008);
    step("r0_wb", BUSY, 16'h0008);

    // Fetch with no ack: 4 request cycles then TRAP; ack in TRAP ignored
    for (int i = 0; i < 4; i++) step("fetch_timeout_wait", MREQ | BUSY, 16'h0009);
    step("trap", ERR, 16'h0009);
    mem_ack = 1'b1;
    step("trap_ignores_ack", ERR, 16'h0009);
    mem_ack = 1'b0;
    step("trap_hold", ERR, 16'h0009);

    rst_n = 1'b0;
    #1 check_now("rst_from_trap", NONE, 16'h0000);
    @(posedge clk); #1; rst_n = 1'b1;

    // Unsupported opcode traps after DECODE
    opcode = 6'b111111;
    step("ill_idle", NONE, 16'h0000);
    fetch_decode(16'h0000);
    step("ill_trap", ERR, 16'h0000);

    rst_n = 1'b0;
    #1 check_now("rst_from_ill", NONE, 16'h0000);
    @(posedge clk); #1; rst_n = 1'b1;

    // Retire one, then reset asynchronously in the middle of MEMRD
    opcode = OP_R; rd = 5'd5;
    step("r2_idle", NONE, 16'h0000);
    fetch_decode(16'h0000);
    step("r2_exec", BUSY, 16'h0000);
    step("r2_wb", BUSY | REGWE, 16'h0000);
    opcode = OP_LW; rt = 5'd3;
    fetch_decode(16'h0001);
    step("lw2_exec", BUSY | AIMM, 16'h0001);
    step("lw2_memrd_wait", MREQ | MSEL | AIMM | BUSY, 16'h0001);
    rst_n = 1'b0;
    #1 check_now("rst_mid_memrd", NONE, 16'h0000);
    run = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    step("idle_after_rst", NONE, 16'h0000);

    // Counter wrap and run=0 at retire
    force dut.retire_cnt = 16'hFFFF;
    #1 release dut.retire_cnt;
    check_now("preload", NONE, 16'hFFFF);
    run = 1'b1; opcode = OP_J;
    step("wrap_idle", NONE, 16'hFFFF);
    fetch_decode(16'hFFFF);
    run = 1'b0;
    step("wrap_exec", BUSY | PCWE | PC_J, 16'hFFFF);
    step("wrap_idle_after", NONE, 16'h0000);
    step("wrap_idle_hold", NONE, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
